// File: rtl/pipe_pkg.sv
// Shared encodings for the miniRV pipeline: ALU ops, branch kinds, writeback selects.
package pipe_pkg;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_SLL = 3'b101,
    ALU_SRL = 3'b110,
    ALU_SRA = 3'b111
  } alu_op_e;

  typedef enum logic [2:0] {
    BR_BEQ  = 3'b000,
    BR_BNE  = 3'b001,
    BR_BLT  = 3'b010,
    BR_BGE  = 3'b011,
    BR_JAL  = 3'b100,
    BR_JALR = 3'b101,
    BR_RSVD = 3'b110,
    BR_NONE = 3'b111
  } br_op_e;

  localparam logic [1:0] WSEL_ALU = 2'b00;
  localparam logic [1:0] WSEL_RAM = 2'b01;
  localparam logic [1:0] WSEL_PC4 = 2'b10;
  localparam logic [1:0] WSEL_EXT = 2'b11;

  localparam int unsigned SQUASH_DEPTH_DEFAULT = 2;

endpackage

// File: rtl/alu.sv
// Combinational ALU for the execute stage; shifts use the low log2(XLEN) bits of B.
module alu
  import pipe_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  input  logic [2:0]      op,
  output logic [XLEN-1:0] result
);

  localparam int unsigned SHW = $clog2(XLEN);

  logic [SHW-1:0] shamt;
  assign shamt = B[SHW-1:0];

  always_comb begin
    result = '0;
    unique case (alu_op_e'(op))
      ALU_ADD: result = A + B;
      ALU_SUB: result = A - B;
      ALU_AND: result = A & B;
      ALU_OR:  result = A | B;
      ALU_XOR: result = A ^ B;
      ALU_SLL: result = A << shamt;
      ALU_SRL: result = A >> shamt;
      ALU_SRA: result = $unsigned($signed(A) >>> shamt);
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/ex_stage.sv
// miniRV execute stage: ALU, branch resolution, PC redirect, wrong-path squash
// and the EX/MEM pipeline register.
module ex_stage
  import pipe_pkg::*;
#(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned SQUASH_DEPTH = SQUASH_DEPTH_DEFAULT
) (
  input  logic            cpu_clk,
  input  logic            cpu_rst,
  input  logic [XLEN-1:0] ext_EX_in,
  input  logic [XLEN-1:0] pc4_EX_in,
  input  logic [4:0]      wR_EX_in,
  input  logic            ram_we_EX_in,
  input  logic [2:0]      alu_op_EX_in,
  input  logic [1:0]      rf_wsel_EX_in,
  input  logic            rf_we_EX_in,
  input  logic [2:0]      br_op_EX_in,
  input  logic [XLEN-1:0] rD1_EX_in,
  input  logic [XLEN-1:0] B_EX_in,
  input  logic [XLEN-1:0] rD2_EX_in,
  output logic            redirect_o,
  output logic [XLEN-1:0] br_target_o,
  output logic [XLEN-1:0] alu_MEM_in,
  output logic [XLEN-1:0] rD2_MEM_in,
  output logic [XLEN-1:0] pc4_MEM_in,
  output logic [XLEN-1:0] ext_MEM_in,
  output logic [4:0]      wR_MEM_in,
  output logic [1:0]      rf_wsel_MEM_in,
  output logic            ram_we_MEM_in,
  output logic            rf_we_MEM_in
);

  localparam logic [1:0] SQ_LOAD = 2'(SQUASH_DEPTH);

  logic [XLEN-1:0] alu_res;
  logic            taken;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] jalr_sum;
  logic            squashing;
  logic [1:0]      sq_cnt_q, sq_cnt_d;

  logic [XLEN-1:0] alu_q, rD2_q, pc4_q, ext_q;
  logic [4:0]      wR_q;
  logic [1:0]      rf_wsel_q;
  logic            ram_we_q, rf_we_q;

  alu #(.XLEN(XLEN)) u_alu (
    .A      (rD1_EX_in),
    .B      (B_EX_in),
    .op     (alu_op_EX_in),
    .result (alu_res)
  );

  assign jalr_sum = rD1_EX_in + ext_EX_in;

  always_comb begin
    taken  = 1'b0;
    target = pc4_EX_in - XLEN'(4) + ext_EX_in;
    unique case (br_op_e'(br_op_EX_in))
      BR_BEQ:  taken = (rD1_EX_in == rD2_EX_in);
      BR_BNE:  taken = (rD1_EX_in != rD2_EX_in);
      BR_BLT:  taken = ($signed(rD1_EX_in) <  $signed(rD2_EX_in));
      BR_BGE:  taken = ($signed(rD1_EX_in) >= $signed(rD2_EX_in));
      BR_JAL:  taken = 1'b1;
      BR_JALR: begin
        taken  = 1'b1;
        target = {jalr_sum[XLEN-1:1], 1'b0};
      end
      default: taken = 1'b0;
    endcase
  end

  // The instruction in EX is on the wrong path while the counter is non-zero.
  assign squashing   = (sq_cnt_q != 2'd0);
  assign redirect_o  = taken & ~squashing;
  assign br_target_o = redirect_o ? target : '0;

  always_comb begin
    sq_cnt_d = sq_cnt_q;
    if (redirect_o)     sq_cnt_d = SQ_LOAD;
    else if (squashing) sq_cnt_d = sq_cnt_q - 2'd1;
  end

  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      sq_cnt_q  <= '0;
      alu_q     <= '0;
      rD2_q     <= '0;
      pc4_q     <= '0;
      ext_q     <= '0;
      wR_q      <= '0;
      rf_wsel_q <= WSEL_ALU;
      ram_we_q  <= 1'b0;
      rf_we_q   <= 1'b0;
    end else begin
      sq_cnt_q  <= sq_cnt_d;
      alu_q     <= alu_res;
      rD2_q     <= rD2_EX_in;
      pc4_q     <= pc4_EX_in;
      ext_q     <= ext_EX_in;
      wR_q      <= wR_EX_in;
      rf_wsel_q <= rf_wsel_EX_in;
      ram_we_q  <= ram_we_EX_in & ~squashing;
      rf_we_q   <= rf_we_EX_in & ~squashing;
    end
  end

  assign alu_MEM_in     = alu_q;
  assign rD2_MEM_in     = rD2_q;
  assign pc4_MEM_in     = pc4_q;
  assign ext_MEM_in     = ext_q;
  assign wR_MEM_in      = wR_q;
  assign rf_wsel_MEM_in = rf_wsel_q;
  assign ram_we_MEM_in  = ram_we_q;
  assign rf_we_MEM_in   = rf_we_q;

endmodule

// File: tb/tb_ex_stage.sv
// Directed self-checking bench for ex_stage with hand-computed expectations.
module tb_ex_stage;
  import pipe_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ext_in, pc4_in, rd1_in, b_in, rd2_in;
  logic [4:0]  wr_in;
  logic        ram_we_in, rf_we_in;
  logic [2:0]  alu_op_in, br_op_in;
  logic [1:0]  wsel_in;
  logic        redirect;
  logic [31:0] target;
  logic [31:0] alu_m, rd2_m, pc4_m, ext_m;
  logic [4:0]  wr_m;
  logic [1:0]  wsel_m;
  logic        ram_we_m, rf_we_m;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  always #5 clk = ~clk;

  ex_stage #(.XLEN(32), .SQUASH_DEPTH(2)) dut (
    .cpu_clk        (clk),
    .cpu_rst        (rst),
    .ext_EX_in      (ext_in),
    .pc4_EX_in      (pc4_in),
    .wR_EX_in       (wr_in),
    .ram_we_EX_in   (ram_we_in),
    .alu_op_EX_in   (alu_op_in),
    .rf_wsel_EX_in  (wsel_in),
    .rf_we_EX_in    (rf_we_in),
    .br_op_EX_in    (br_op_in),
    .rD1_EX_in      (rd1_in),
    .B_EX_in        (b_in),
    .rD2_EX_in      (rd2_in),
    .redirect_o     (redirect),
    .br_target_o    (target),
    .alu_MEM_in     (alu_m),
    .rD2_MEM_in     (rd2_m),
    .pc4_MEM_in     (pc4_m),
    .ext_MEM_in     (ext_m),
    .wR_MEM_in      (wr_m),
    .rf_wsel_MEM_in (wsel_m),
    .ram_we_MEM_in  (ram_we_m),
    .rf_we_MEM_in   (rf_we_m)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [2:0] aop, input logic [2:0] bop,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] d2,
                       input logic [31:0] e, input logic [31:0] p4, input logic [4:0] wr,
                       input logic [1:0] ws, input logic rfwe, input logic ramwe);
    alu_op_in = aop; br_op_in = bop; rd1_in = a; b_in = b; rd2_in = d2;
    ext_in = e; pc4_in = p4; wr_in = wr; wsel_in = ws; rf_we_in = rfwe; ram_we_in = ramwe;
  endtask

  task automatic nop(input logic rfwe, input logic ramwe);
    drive(ALU_ADD, BR_NONE, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, WSEL_ALU, rfwe, ramwe);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic alu_vec(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp);
    drive(op, BR_NONE, a, b, 32'h0, 32'h0, 32'h0, 5'd3, WSEL_ALU, 1'b1, 1'b0);
    tick();
    chk(tag, alu_m, exp);
  endtask

  initial begin
    // Reset with random data, two cycles
    rst = 1'b1;
    drive(3'($urandom), BR_NONE, $urandom, $urandom, $urandom, $urandom, $urandom,
          5'($urandom), 2'($urandom), 1'b1, 1'b1);
    tick();
    tick();
    chk("rst_alu", alu_m, 32'h0);
    chk("rst_rd2", rd2_m, 32'h0);
    chk("rst_pc4", pc4_m, 32'h0);
    chk("rst_ext", ext_m, 32'h0);
    chk("rst_wr", 32'(wr_m), 32'h0);
    chk("rst_wsel", 32'(wsel_m), 32'h0);
    chk("rst_ramwe", 32'(ram_we_m), 32'h0);
    chk("rst_rfwe", 32'(rf_we_m), 32'h0);
    chk("rst_redirect", 32'(redirect), 32'h0);
    chk("rst_target", target, 32'h0);
    rst = 1'b0;

    // First instruction after reset: all fields pass through, not squashed
    drive(ALU_SUB, BR_NONE, 32'h8000_0000, 32'h8000_0000, 32'h33, 32'h7, 32'h10,
          5'd5, WSEL_EXT, 1'b1, 1'b1);
    tick();
    chk("sub_ovf", alu_m, 32'h0);
    chk("pt_rd2", rd2_m, 32'h33);
    chk("pt_pc4", pc4_m, 32'h10);
    chk("pt_ext", ext_m, 32'h7);
    chk("pt_wr", 32'(wr_m), 32'd5);
    chk("pt_wsel", 32'(wsel_m), 32'(WSEL_EXT));
    chk("pt_rfwe", 32'(rf_we_m), 32'h1);
    chk("pt_ramwe", 32'(ram_we_m), 32'h1);

    alu_vec("sra31", ALU_SRA, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF);
    alu_vec("add_wrap", ALU_ADD, 32'hFFFF_FFFF, 32'h1, 32'h0);
    alu_vec("sll_b40", ALU_SLL, 32'h1, 32'h24, 32'h10);
    alu_vec("srl31", ALU_SRL, 32'h8000_0000, 32'd31, 32'h1);
    alu_vec("and", ALU_AND, 32'hF0F0_FF00, 32'h0FF0_F0F0, 32'h00F0_F000);
    alu_vec("or", ALU_OR, 32'hF0F0_FF00, 32'h0FF0_F0F0, 32'hFFF0_FFF0);
    alu_vec("xor", ALU_XOR, 32'hF0F0_FF00, 32'h0FF0_F0F0, 32'hFF00_0FF0);

    // BGE -1 >= 1 is false (signed)
    drive(ALU_ADD, BR_BGE, 32'hFFFF_FFFF, 32'h0, 32'h1, 32'h20, 32'h104, 5'd0, WSEL_ALU, 1'b0, 1'b0);
    #1;
    chk("bge_nt_redir", 32'(redirect), 32'h0);
    chk("bge_nt_tgt", target, 32'h0);

    // BLT -1 < 1 taken, target 0x100+0x20
    br_op_in = BR_BLT;
    #1;
    chk("blt_redir", 32'(redirect), 32'h1);
    chk("blt_tgt", target, 32'h120);
    tick();
    // First wrong-path slot: a taken BEQ that must be ignored
    drive(ALU_ADD, BR_BEQ, 32'h5, 32'h0, 32'h5, 32'h40, 32'h200, 5'd7, WSEL_ALU, 1'b1, 1'b1);
    #1;
    chk("sq1_redir", 32'(redirect), 32'h0);
    chk("sq1_tgt", target, 32'h0);
    tick();
    chk("sq1_rfwe", 32'(rf_we_m), 32'h0);
    chk("sq1_ramwe", 32'(ram_we_m), 32'h0);
    chk("sq1_wr", 32'(wr_m), 32'd7);
    nop(1'b1, 1'b1);
    tick();
    chk("sq2_rfwe", 32'(rf_we_m), 32'h0);
    chk("sq2_ramwe", 32'(ram_we_m), 32'h0);
    nop(1'b1, 1'b1);
    tick();
    chk("sq3_rfwe", 32'(rf_we_m), 32'h1);
    chk("sq3_ramwe", 32'(ram_we_m), 32'h1);

    // JALR: target bit 0 cleared, link written
    drive(ALU_ADD, BR_JALR, 32'h1001, 32'h0, 32'h0, 32'h2, 32'h204, 5'd1, WSEL_PC4, 1'b1, 1'b0);
    #1;
    chk("jalr_redir", 32'(redirect), 32'h1);
    chk("jalr_tgt", target, 32'h1002);
    tick();
    chk("jalr_wsel", 32'(wsel_m), 32'(WSEL_PC4));
    chk("jalr_pc4", pc4_m, 32'h204);
    chk("jalr_rfwe", 32'(rf_we_m), 32'h1);
    nop(1'b0, 1'b0);
    tick();
    tick();

    // Back-to-back JAL: second one is squashed
    drive(ALU_ADD, BR_JAL, 32'h0, 32'h0, 32'h0, 32'h40, 32'h304, 5'd1, WSEL_PC4, 1'b1, 1'b0);
    #1;
    chk("jal1_redir", 32'(redirect), 32'h1);
    chk("jal1_tgt", target, 32'h340);
    tick();
    chk("jal1_rfwe", 32'(rf_we_m), 32'h1);
    drive(ALU_ADD, BR_JAL, 32'h0, 32'h0, 32'h0, 32'h80, 32'h344, 5'd2, WSEL_PC4, 1'b1, 1'b0);
    #1;
    chk("jal2_redir", 32'(redirect), 32'h0);
    chk("jal2_tgt", target, 32'h0);
    tick();
    chk("jal2_rfwe", 32'(rf_we_m), 32'h0);
    nop(1'b0, 1'b0);
    tick();
    // Third slot after JAL1 is on the correct path
    drive(ALU_ADD, BR_BNE, 32'h1, 32'h0, 32'h2, 32'h10, 32'h504, 5'd0, WSEL_ALU, 1'b0, 1'b0);
    #1;
    chk("bne_redir", 32'(redirect), 32'h1);
    chk("bne_tgt", target, 32'h510);
    tick();
    nop(1'b0, 1'b0);
    tick();
    tick();

    // Mid-squash reset: BEQ taken at t, reset at t+1, store at t+2
    drive(ALU_ADD, BR_BEQ, 32'h9, 32'h0, 32'h9, 32'h8, 32'h604, 5'd0, WSEL_ALU, 1'b0, 1'b0);
    #1;
    chk("beq_redir", 32'(redirect), 32'h1);
    chk("beq_tgt", target, 32'h608);
    tick();
    rst = 1'b1;
    nop(1'b1, 1'b1);
    tick();
    chk("mrst_alu", alu_m, 32'h0);
    chk("mrst_rfwe", 32'(rf_we_m), 32'h0);
    rst = 1'b0;
    drive(ALU_ADD, BR_BEQ, 32'h3, 32'h4, 32'h3, 32'hFFFF_FFF8, 32'h404, 5'd0, WSEL_ALU, 1'b0, 1'b1);
    #1;
    chk("post_rst_redir", 32'(redirect), 32'h1);
    chk("post_rst_tgt", target, 32'h3F8);
    tick();
    chk("post_rst_ramwe", 32'(ram_we_m), 32'h1);
    chk("post_rst_alu", alu_m, 32'h7);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
